// File: rtl/gemm_mem_responder_pkg.sv
// Shared types for the gemm memory responder: line layout, pipeline response tag,
// and the byte-address to line-index helper.
package gemm_mem_responder_pkg;

  localparam int LANES      = 4;
  localparam int LANE_W     = 32;
  localparam int LINE_BYTES = 16;
  localparam int LANE_IDX_W = $clog2(LANES);

  typedef logic [LANES-1:0][LANE_W-1:0] line_t;

  // oor marks an out-of-range line so the read path can force zero data
  typedef struct packed {
    logic                  valid;
    logic                  is_host;
    logic [LANE_IDX_W-1:0] lane;
    logic                  last;
    logic                  oor;
  } resp_tag_t;

  function automatic logic [31:0] line_of(input logic [31:0] addr);
    return addr >> $clog2(LINE_BYTES);
  endfunction

endpackage

// File: rtl/gemm_line_ram.sv
// Single-port line RAM: synchronous read, per-lane write enables, DEPTH x 128 bits.
module gemm_line_ram
  import gemm_mem_responder_pkg::*;
#(
  parameter int DEPTH = 4096,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             en_i,
  input  logic [LANES-1:0] we_i,
  input  logic [AW-1:0]    addr_i,
  input  line_t            wdata_i,
  output line_t            rdata_o
);

  line_t mem_q [DEPTH];
  line_t rdata_q;

  always_ff @(posedge clk) begin
    if (en_i) begin
      for (int l = 0; l < LANES; l++) begin
        if (we_i[l]) mem_q[addr_i][l] <= wdata_i[l];
      end
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/gemm_mem_responder.sv
// Memory-side responder for gemm: gemm line reads/writes always win the single RAM port,
// a 32-bit host port uses idle cycles. Fixed read latency of READ_LAT (1 or 2) cycles.
module gemm_mem_responder
  import gemm_mem_responder_pkg::*;
#(
  parameter int DEPTH    = 4096,
  parameter int READ_LAT = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         interface_en,
  input  logic         interface_rdwr,
  input  logic [31:0]  interface_addr,
  input  logic [4:0]   interface_control,
  input  logic [127:0] interface_wr_data,
  output logic [127:0] interface_rd_data,
  input  logic         host_en,
  input  logic         host_rdwr,
  input  logic [31:0]  host_addr,
  input  logic [31:0]  host_wr_data,
  output logic         host_ready,
  output logic [31:0]  host_rd_data,
  output logic         host_rd_valid,
  output logic         tile_done,
  output logic         addr_err
);

  localparam int AW = $clog2(DEPTH);

  logic              gemm_req, host_acc;
  logic [31:0]       req_addr, req_line;
  logic              req_oor, req_misalign, req_rd;
  logic [LANES-1:0]  ram_we;
  line_t             ram_wdata, ram_rdata, rd_line;
  resp_tag_t         s1_d, s1_q;
  logic              gemm_rsp, host_rsp;
  line_t             rd_hold_q;
  logic [LANE_W-1:0] hrd_hold_q;
  logic              hrd_valid_q, rd_last_q, wr_last_q, addr_err_q;
  logic              rd_last;

  // Stage 0: request decode. gemm owns the port whenever it asks.
  assign host_ready   = rst & ~interface_en;
  assign gemm_req     = rst & interface_en;
  assign host_acc     = host_ready & host_en;
  assign req_addr     = gemm_req ? interface_addr : host_addr;
  assign req_line     = line_of(req_addr);
  assign req_oor      = req_line >= 32'(DEPTH);
  assign req_misalign = gemm_req ? (interface_addr[3:0] != 4'd0) : (host_addr[1:0] != 2'd0);
  assign req_rd       = gemm_req ? ~interface_rdwr : ~host_rdwr;

  always_comb begin
    ram_we    = '0;
    ram_wdata = interface_wr_data;
    if (gemm_req) begin
      if (interface_rdwr && !req_oor) ram_we = interface_control[LANES-1:0];
    end else if (host_acc) begin
      ram_wdata = {LANES{host_wr_data}};
      if (host_rdwr && !req_oor) ram_we = LANES'(1) << host_addr[3:2];
    end
  end

  always_comb begin
    s1_d         = '0;
    s1_d.valid   = (gemm_req | host_acc) & req_rd;
    s1_d.is_host = host_acc;
    s1_d.lane    = host_addr[3:2];
    s1_d.last    = gemm_req & interface_control[4];
    s1_d.oor     = req_oor;
  end

  // Stage 1: RAM access; the tag travels alongside the synchronous read.
  gemm_line_ram #(.DEPTH(DEPTH)) u_ram (
    .clk     (clk),
    .en_i    (gemm_req | host_acc),
    .we_i    (ram_we),
    .addr_i  (req_line[AW-1:0]),
    .wdata_i (ram_wdata),
    .rdata_o (ram_rdata)
  );

  assign rd_line  = s1_q.oor ? '0 : ram_rdata;
  assign gemm_rsp = s1_q.valid & ~s1_q.is_host;
  assign host_rsp = s1_q.valid & s1_q.is_host;

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_q        <= '0;
      rd_hold_q   <= '0;
      hrd_hold_q  <= '0;
      hrd_valid_q <= 1'b0;
      rd_last_q   <= 1'b0;
      wr_last_q   <= 1'b0;
      addr_err_q  <= 1'b0;
    end else begin
      s1_q        <= s1_d;
      hrd_valid_q <= host_rsp;
      rd_last_q   <= gemm_rsp & s1_q.last;
      wr_last_q   <= gemm_req & interface_rdwr & interface_control[4];
      if (gemm_rsp) rd_hold_q <= rd_line;
      if (host_rsp) hrd_hold_q <= rd_line[s1_q.lane];
      if ((gemm_req | host_acc) && (req_misalign || req_oor)) addr_err_q <= 1'b1;
    end
  end

  // Stage 2 exists only for READ_LAT=2; the hold registers double as the output register.
  if (READ_LAT == 1) begin : g_lat1
    assign interface_rd_data = gemm_rsp ? rd_line : rd_hold_q;
    assign host_rd_data      = host_rsp ? rd_line[s1_q.lane] : hrd_hold_q;
    assign host_rd_valid     = host_rsp;
    assign rd_last           = gemm_rsp & s1_q.last;
  end else begin : g_lat2
    assign interface_rd_data = rd_hold_q;
    assign host_rd_data      = hrd_hold_q;
    assign host_rd_valid     = hrd_valid_q;
    assign rd_last           = rd_last_q;
  end

  assign tile_done = wr_last_q | rd_last;
  assign addr_err  = addr_err_q;

endmodule

// File: tb/tb_gemm_mem_responder.sv
// Bench for gemm_mem_responder: directed scenarios plus random traffic, checked by a
// line-array reference model and per-cycle monitor against scheduled responses.
module tb_gemm_mem_responder;
  import gemm_mem_responder_pkg::*;

  localparam int DEPTH     = 4096;
  localparam int READ_LAT  = 2;
  localparam int MEM_LINES = 64;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic         interface_en = 1'b0, interface_rdwr = 1'b0;
  logic [31:0]  interface_addr = '0;
  logic [4:0]   interface_control = '0;
  logic [127:0] interface_wr_data = '0;
  logic [127:0] interface_rd_data;
  logic         host_en = 1'b0, host_rdwr = 1'b0;
  logic [31:0]  host_addr = '0, host_wr_data = '0;
  logic         host_ready, host_rd_valid, tile_done, addr_err;
  logic [31:0]  host_rd_data;

  gemm_mem_responder #(.DEPTH(DEPTH), .READ_LAT(READ_LAT)) dut (
    .clk               (clk),
    .rst               (rst),
    .interface_en      (interface_en),
    .interface_rdwr    (interface_rdwr),
    .interface_addr    (interface_addr),
    .interface_control (interface_control),
    .interface_wr_data (interface_wr_data),
    .interface_rd_data (interface_rd_data),
    .host_en           (host_en),
    .host_rdwr         (host_rdwr),
    .host_addr         (host_addr),
    .host_wr_data      (host_wr_data),
    .host_ready        (host_ready),
    .host_rd_data      (host_rd_data),
    .host_rd_valid     (host_rd_valid),
    .tile_done         (tile_done),
    .addr_err          (addr_err)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_errors = 0;

  line_t       mem [MEM_LINES];
  logic [127:0] g_exp_q[$];
  int           g_due_q[$];
  logic [31:0]  h_exp_q[$];
  int           h_due_q[$];
  bit           td_exp[int];
  int           err_cyc = -1;
  line_t        exp_rd = '0;
  logic [31:0]  exp_hrd = '0;
  bit           mon_en = 1'b0;

  bit           h_pend = 1'b0, h_wr = 1'b0;
  logic [31:0]  h_addr = '0, h_data = '0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  function automatic int line_idx(input logic [31:0] a);
    return int'(a >> 4);
  endfunction

  function automatic void note_err();
    if (err_cyc < 0) err_cyc = cyc + 1;
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (mon_en) begin
      bit hv;
      if (g_due_q.size() > 0 && g_due_q[0] == cyc) begin
        exp_rd = g_exp_q.pop_front();
        void'(g_due_q.pop_front());
      end
      hv = (h_due_q.size() > 0 && h_due_q[0] == cyc);
      if (hv) begin
        exp_hrd = h_exp_q.pop_front();
        void'(h_due_q.pop_front());
      end
      chk("gemm_rd_data", interface_rd_data, exp_rd);
      chk("host_rd_valid", host_rd_valid, hv);
      chk("host_rd_data", host_rd_data, exp_hrd);
      chk("tile_done", tile_done, td_exp.exists(cyc));
      chk("addr_err", addr_err, (err_cyc >= 0 && cyc >= err_cyc));
    end
  end

  // ---------------- driver tasks ----------------
  // One clock cycle: drive gemm request and any pending host request, update the model.
  task automatic step(input bit g_en, input bit g_wr, input logic [31:0] g_addr,
                      input logic [4:0] g_ctl, input line_t g_data);
    int ln;
    bit oor;
    @(posedge clk); #1;
    interface_en      = g_en;
    interface_rdwr    = g_wr;
    interface_addr    = g_addr;
    interface_control = g_ctl;
    interface_wr_data = g_data;
    host_en      = h_pend;
    host_rdwr    = h_wr;
    host_addr    = h_addr;
    host_wr_data = h_data;
    #1;
    chk("host_ready", host_ready, !g_en);
    if (g_en) begin
      ln  = line_idx(g_addr);
      oor = (ln >= DEPTH);
      if (g_addr[3:0] != 4'd0 || oor) note_err();
      if (g_wr) begin
        if (!oor) for (int l = 0; l < LANES; l++) if (g_ctl[l]) mem[ln][l] = g_data[l];
        if (g_ctl[4]) td_exp[cyc + 1] = 1'b1;
      end else begin
        g_exp_q.push_back(oor ? '0 : mem[ln]);
        g_due_q.push_back(cyc + READ_LAT);
        if (g_ctl[4]) td_exp[cyc + READ_LAT] = 1'b1;
      end
    end else if (h_pend) begin
      ln  = line_idx(h_addr);
      oor = (ln >= DEPTH);
      if (h_addr[1:0] != 2'd0 || oor) note_err();
      if (h_wr) begin
        if (!oor) mem[ln][h_addr[3:2]] = h_data;
      end else begin
        h_exp_q.push_back(oor ? 32'd0 : mem[ln][h_addr[3:2]]);
        h_due_q.push_back(cyc + READ_LAT);
      end
      h_pend = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'd0, 5'd0, '0);
  endtask

  task automatic gemm_rd(input logic [31:0] a, input logic [4:0] ctl);
    step(1'b1, 1'b0, a, ctl, '0);
  endtask

  task automatic gemm_wr(input logic [31:0] a, input logic [4:0] ctl, input line_t d);
    step(1'b1, 1'b1, a, ctl, d);
  endtask

  task automatic host_op(input bit wr, input logic [31:0] a, input logic [31:0] d);
    h_pend = 1'b1; h_wr = wr; h_addr = a; h_data = d;
  endtask

  task automatic do_reset(input int n);
    @(posedge clk); #1;
    rst = 1'b0; mon_en = 1'b0;
    interface_en = 1'b0; host_en = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b1;
    g_exp_q.delete(); g_due_q.delete(); h_exp_q.delete(); h_due_q.delete();
    td_exp.delete();
    err_cyc = -1; exp_rd = '0; exp_hrd = '0; h_pend = 1'b0;
    mon_en = 1'b1;
  endtask

  function automatic line_t rand_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    line_t d;
    do_reset(2);

    // zero every line the bench touches so no read sees uninitialised RAM
    for (int i = 0; i < MEM_LINES; i++) gemm_wr(32'(i) << 4, 5'h0F, '0);
    idle(2);

    // host preload then gemm line read
    host_op(1'b1, 32'h100, 32'h11); idle(1);
    host_op(1'b1, 32'h104, 32'h22); idle(1);
    host_op(1'b1, 32'h108, 32'h33); idle(1);
    host_op(1'b1, 32'h10C, 32'h44); idle(1);
    gemm_rd(32'h100, 5'h00);
    idle(READ_LAT + 1);
    chk("t1_line", interface_rd_data, 128'h00000044_00000033_00000022_00000011);

    // partial-lane gemm write, host readback
    d = {32'hDDDD_000D, 32'hCCCC_000C, 32'hBBBB_000B, 32'hAAAA_000A};
    gemm_wr(32'h200, 5'b00101, d);
    for (int i = 0; i < 4; i++) begin host_op(1'b0, 32'h200 + 32'(4 * i), 32'd0); idle(1); end
    idle(READ_LAT + 1);

    // host write starved by 10 back-to-back gemm reads
    host_op(1'b1, 32'h120, 32'hCAFE_F00D);
    for (int i = 0; i < 10; i++) gemm_rd(32'(i % 3) << 8, 5'h00);
    idle(1);
    host_op(1'b0, 32'h120, 32'd0); idle(1);
    idle(READ_LAT + 1);
    chk("t3_host_rd", host_rd_data, 32'hCAFE_F00D);

    // write then read same line next cycle, read marks last
    d = rand_line();
    gemm_wr(32'h40, 5'h0F, d);
    gemm_rd(32'h40, 5'h10);
    idle(READ_LAT + 1);
    chk("t4_line", interface_rd_data, d);

    // misaligned and out-of-range accesses
    gemm_rd(32'h104, 5'h00);
    gemm_rd(32'(DEPTH) << 4, 5'h00);
    gemm_wr(32'(DEPTH) << 4, 5'h0F, rand_line());
    gemm_rd(32'h0, 5'h00);
    idle(READ_LAT + 1);
    chk("t5_err_sticky", addr_err, 1'b1);

    // reset with reads in flight
    gemm_rd(32'h100, 5'h10);
    gemm_rd(32'h200, 5'h10);
    do_reset(1);
    chk("t6_rd_reset", interface_rd_data, 128'd0);
    idle(READ_LAT + 2);
    gemm_rd(32'h100, 5'h00);
    host_op(1'b0, 32'h208, 32'd0); idle(1);
    idle(READ_LAT + 1);

    // randomized mixed traffic
    for (int i = 0; i < 400; i++) begin
      logic [31:0] ga;
      if (!h_pend && $urandom_range(0, 2) == 0) begin
        host_op(1'($urandom_range(0, 1)),
                ($urandom_range(0, 15) == 0 ? (32'(DEPTH) << 4) : (32'($urandom_range(0, 15)) << 4))
                  | (32'($urandom_range(0, 3)) << 2),
                $urandom);
      end
      ga = ($urandom_range(0, 15) == 0) ? (32'(DEPTH + $urandom_range(0, 3)) << 4)
                                         : (32'($urandom_range(0, 15)) << 4);
      if ($urandom_range(0, 1) == 1)
        step(1'b1, 1'($urandom_range(0, 1)), ga, 5'($urandom_range(0, 31)), rand_line());
      else
        idle(1);
    end
    idle(READ_LAT + 3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
